// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message-schedule expander: FSM states,
// per-width small-sigma rotation/shift amounts and default schedule lengths.
package sha2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      EXPAND = 2'd2
   } sched_state_e;

   localparam int WIN_DEPTH  = 16;
   localparam int ROUNDS_256 = 64;
   localparam int ROUNDS_512 = 80;

   // idx 0/1 select the two rotate amounts, idx 2 the plain right shift.
   function automatic int sigmaAmount(input int wordW, input int sel, input int idx);
      int amt;
      amt = 0;
      if (wordW == 64) begin
         if (sel == 0) amt = (idx == 0) ? 1  : (idx == 1) ? 8  : 7;
         else          amt = (idx == 0) ? 19 : (idx == 1) ? 61 : 6;
      end else begin
         if (sel == 0) amt = (idx == 0) ? 7  : (idx == 1) ? 18 : 3;
         else          amt = (idx == 0) ? 17 : (idx == 1) ? 19 : 10;
      end
      return amt;
   endfunction

   function automatic int defaultRounds(input int wordW);
      return (wordW == 64) ? ROUNDS_512 : ROUNDS_256;
   endfunction

endpackage

// File: rtl/sched_sigma.sv
// Combinational SHA-2 small-sigma function: SEL=0 gives s0, SEL=1 gives s1,
// with constants chosen by WORD_W (32 = SHA-256, 64 = SHA-512).
module sched_sigma
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int SEL    = 0
) (
   input  logic [WORD_W-1:0] word_i,
   output logic [WORD_W-1:0] sigma_o
);

   localparam int ROT_A = sigmaAmount(WORD_W, SEL, 0);
   localparam int ROT_B = sigmaAmount(WORD_W, SEL, 1);
   localparam int SHR   = sigmaAmount(WORD_W, SEL, 2);

   if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_width
      $error("sched_sigma: WORD_W must be 32 or 64");
   end
   if (!(SEL == 0 || SEL == 1)) begin : g_bad_sel
      $error("sched_sigma: SEL must be 0 (s0) or 1 (s1)");
   end

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int r);
      return (x >> r) | (x << (WORD_W - r));
   endfunction

   assign sigma_o = rotr(word_i, ROT_A) ^ rotr(word_i, ROT_B) ^ (word_i >> SHR);

endmodule

// File: rtl/msg_schedule_expander.sv
// Streaming SHA-2 message schedule: loads a 16-word block, then emits W[0..ROUNDS-1].
// Optional feature: define SCHED_IDX_EN to add the out_idx port (current round t).
module msg_schedule_expander
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ROUNDS = defaultRounds(WORD_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic              busy,
   output logic              done
`ifdef SCHED_IDX_EN
   ,
   output logic [7:0]        out_idx
`endif
);

   if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_width
      $error("msg_schedule_expander: WORD_W must be 32 or 64");
   end
   if (ROUNDS < 16 || ROUNDS > 256) begin : g_bad_rounds
      $error("msg_schedule_expander: ROUNDS must be in 16..256");
   end

   localparam logic [3:0] LAST_LOAD  = 4'd15;
   localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

   sched_state_e      state_q, state_d;
   logic [WORD_W-1:0] win_q [WIN_DEPTH];
   logic [WORD_W-1:0] win_d [WIN_DEPTH];
   logic [7:0]        t_q, t_d;
   logic [3:0]        n_q, n_d;
   logic              done_q, done_d;

   logic              inFire, outFire;
   logic              shiftEn;
   logic [WORD_W-1:0] shiftWord;
   logic [WORD_W-1:0] sigma0, sigma1, schedNext;

   sched_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (
      .word_i  (win_q[1]),
      .sigma_o (sigma0)
   );

   sched_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (
      .word_i  (win_q[14]),
      .sigma_o (sigma1)
   );

   // Sum wraps naturally at WORD_W bits, giving the mod 2^WORD_W addition.
   assign schedNext = sigma1 + win_q[9] + sigma0 + win_q[0];

   assign in_ready  = (state_q != EXPAND);
   assign out_valid = (state_q == EXPAND);
   assign out_word  = win_q[0];
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
`ifdef SCHED_IDX_EN
   assign out_idx   = t_q;
`endif

   assign inFire  = in_valid & in_ready;
   assign outFire = out_valid & out_ready;

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      n_d       = n_q;
      done_d    = 1'b0;
      shiftEn   = 1'b0;
      shiftWord = in_word;
      unique case (state_q)
         IDLE: begin
            if (inFire) begin
               shiftEn = 1'b1;
               n_d     = 4'd1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (inFire) begin
               shiftEn = 1'b1;
               n_d     = n_q + 4'd1;
               if (n_q == LAST_LOAD) begin
                  state_d = EXPAND;
                  t_d     = 8'd0;
               end
            end
         end
         EXPAND: begin
            if (outFire) begin
               shiftEn   = 1'b1;
               shiftWord = schedNext;
               t_d       = t_q + 8'd1;
               if (t_q == LAST_ROUND) begin
                  state_d = IDLE;
                  t_d     = 8'd0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Loading and expanding both push one word into the top of the window.
   always_comb begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
         win_d[i] = win_q[i];
      end
      if (shiftEn) begin
         for (int i = 0; i < WIN_DEPTH - 1; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[WIN_DEPTH-1] = shiftWord;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         n_q     <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < WIN_DEPTH; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         n_q     <= n_d;
         done_q  <= done_d;
         for (int i = 0; i < WIN_DEPTH; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

endmodule

// File: tb/tb_msg_schedule_expander.sv
// Self-checking bench for msg_schedule_expander: SHA-256 and SHA-512 instances
// driven with directed and random blocks against a plain-arithmetic schedule model.
module tb_msg_schedule_expander;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        inValid32, inReady32, outValid32, outReady32, busy32, done32;
   logic [31:0] inWord32, outWord32;
   logic        inValid64, inReady64, outValid64, outReady64, busy64, done64;
   logic [63:0] inWord64, outWord64;
`ifdef SCHED_IDX_EN
   logic [7:0]  outIdx32, outIdx64;
`endif

   int total = 0;
   int bad   = 0;

   logic [63:0] blk   [16];
   logic [63:0] sched [80];
   logic [63:0] got   [80];
   logic [63:0] inQ   [$];
   logic [63:0] expQ  [$];

   always #5 clk = ~clk;

   msg_schedule_expander #(.WORD_W(32), .ROUNDS(64)) dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid32),
      .in_ready  (inReady32),
      .in_word   (inWord32),
      .out_valid (outValid32),
      .out_ready (outReady32),
      .out_word  (outWord32),
      .busy      (busy32),
      .done      (done32)
`ifdef SCHED_IDX_EN
      ,
      .out_idx   (outIdx32)
`endif
   );

   msg_schedule_expander #(.WORD_W(64), .ROUNDS(80)) dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid64),
      .in_ready  (inReady64),
      .in_word   (inWord64),
      .out_valid (outValid64),
      .out_ready (outReady64),
      .out_word  (outWord64),
      .busy      (busy64),
      .done      (done64)
`ifdef SCHED_IDX_EN
      ,
      .out_idx   (outIdx64)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
      logic [63:0] mask;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      return ((x >> r) | (x << (w - r))) & mask;
   endfunction

   function automatic logic [63:0] smallSigma(input bit is64, input bit sel, input logic [63:0] x);
      if (!is64)
         return sel ? (rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10))
                    : (rotr(x, 7, 32)  ^ rotr(x, 18, 32) ^ (x >> 3));
      return sel ? (rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6))
                 : (rotr(x, 1, 64)  ^ rotr(x, 8, 64)  ^ (x >> 7));
   endfunction

   // Standard schedule recurrence, indexed directly by round number.
   task automatic enqueueBlock(input bit is64, input int rounds);
      logic [63:0] mask;
      mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      for (int t = 0; t < 16; t++) sched[t] = blk[t] & mask;
      for (int t = 16; t < rounds; t++)
         sched[t] = (smallSigma(is64, 1'b1, sched[t-2]) + sched[t-7]
                     + smallSigma(is64, 1'b0, sched[t-15]) + sched[t-16]) & mask;
      for (int t = 0; t < 16; t++) inQ.push_back(sched[t]);
      for (int t = 0; t < rounds; t++) expQ.push_back(sched[t]);
   endtask

   task automatic randomBlock();
      for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
   endtask

   task automatic applyStimulus(input bit is64, input bit v, input logic [63:0] w, input bit r);
      if (is64) begin
         inValid64 = v; inWord64 = w; outReady64 = r;
      end else begin
         inValid32 = v; inWord32 = w[31:0]; outReady32 = r;
      end
   endtask

   task automatic sampleOutputs(input bit is64, output bit ir, output bit ov,
                                output logic [63:0] ow, output bit dn, output logic [7:0] idx);
      idx = 8'd0;
      if (is64) begin
         ir = inReady64; ov = outValid64; ow = outWord64; dn = done64;
`ifdef SCHED_IDX_EN
         idx = outIdx64;
`endif
      end else begin
         ir = inReady32; ov = outValid32; ow = {32'h0, outWord32}; dn = done32;
`ifdef SCHED_IDX_EN
         idx = outIdx32;
`endif
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: repeating 1-0-0-1 ready pattern.
   task automatic runStream(input bit is64, input int rounds, input int mode, input int stopAfter);
      int          outCount, inCount, doneSeen, cycles, nBlocks;
      bit          expectDone, expectValid, holdPrev;
      bit          v, r, ir, ov, dn;
      bit          pat [4];
      logic [63:0] ow, prevWord, w, e;
      logic [7:0]  idx;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      outCount = 0; inCount = 0; doneSeen = 0; cycles = 0;
      nBlocks = expQ.size() / rounds;
      expectDone = 0; expectValid = 0; holdPrev = 0; prevWord = '0;
      while ((inQ.size() > 0 || expQ.size() > 0 || expectDone) && cycles < 4000
             && !(stopAfter > 0 && outCount >= stopAfter)) begin
         @(negedge clk);
         cycles++;
         v = (inQ.size() > 0);
         w = v ? inQ[0] : 64'h0;
         r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : pat[cycles % 4];
         applyStimulus(is64, v, w, r);
         #1;
         sampleOutputs(is64, ir, ov, ow, dn, idx);
         checkOutput("done", 64'(dn), 64'(expectDone));
         if (expectDone) checkOutput("inReadyAtDone", 64'(ir), 64'd1);
         expectDone = 0;
         if (dn) doneSeen++;
         if (expectValid) checkOutput("latency", 64'(ov), 64'd1);
         expectValid = 0;
         if (holdPrev) checkOutput("holdWord", ow, prevWord);
         holdPrev = 0;
`ifdef SCHED_IDX_EN
         if (ov) checkOutput("idx", 64'(idx), 64'(outCount % rounds));
`endif
         if (v && ir) begin
            void'(inQ.pop_front());
            inCount++;
            if (inCount % 16 == 0) expectValid = 1;
         end
         if (ov && r) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            checkOutput($sformatf("W%0d", outCount % rounds), ow, e);
            got[outCount % rounds] = ow;
            outCount++;
            if (outCount % rounds == 0) expectDone = 1;
         end else if (ov) begin
            holdPrev = 1;
            prevWord = ow;
         end
      end
      if (cycles >= 4000) checkOutput("timeout", 64'd1, 64'd0);
      if (stopAfter == 0) checkOutput("doneCount", 64'(doneSeen), 64'(nBlocks));
   endtask

   initial begin
      bit          ir, ov, dn;
      logic [63:0] ow;
      logic [7:0]  idx;

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
      repeat (2) @(negedge clk);
      sampleOutputs(1'b0, ir, ov, ow, dn, idx);
      checkOutput("rstInReady", 64'(ir), 64'd1);
      checkOutput("rstOutValid", 64'(ov), 64'd0);
      checkOutput("rstOutWord", ow, 64'd0);
      checkOutput("rstDone", 64'(dn), 64'd0);
      checkOutput("rstBusy", 64'(busy32), 64'd0);
      checkOutput("rstIdx", 64'(idx), 64'd0);
      checkOutput("rstOutValid64", 64'(outValid64), 64'd0);
      rst_n = 1'b1;

      $display("[TB] abc block, SHA-256, random back-pressure");
      for (int i = 0; i < 16; i++) blk[i] = 64'h0;
      blk[0]  = 64'h6162_6380;
      blk[15] = 64'h18;
      enqueueBlock(1'b0, 64);
      runStream(1'b0, 64, 1, 0);
      checkOutput("abcW16", got[16], 64'h6162_6380);
      checkOutput("abcW17", got[17], 64'h000F_0000);

      $display("[TB] all-zero block");
      for (int i = 0; i < 16; i++) blk[i] = 64'h0;
      enqueueBlock(1'b0, 64);
      runStream(1'b0, 64, 0, 0);

      $display("[TB] random block with 1-0-0-1 ready pattern");
      randomBlock();
      enqueueBlock(1'b0, 64);
      runStream(1'b0, 64, 2, 0);

      $display("[TB] reset during expansion at t=30");
      randomBlock();
      enqueueBlock(1'b0, 64);
      runStream(1'b0, 64, 0, 30);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
      #1;
      sampleOutputs(1'b0, ir, ov, ow, dn, idx);
      checkOutput("midExpandValid", 64'(ov), 64'd1);
`ifdef SCHED_IDX_EN
      checkOutput("midExpandIdx", 64'(idx), 64'd30);
`endif
      checkOutput("midExpandWord", ow, sched[30]);
      rst_n = 1'b0;
      #1;
      sampleOutputs(1'b0, ir, ov, ow, dn, idx);
      checkOutput("abortOutValid", 64'(ov), 64'd0);
      checkOutput("abortInReady", 64'(ir), 64'd1);
      checkOutput("abortDone", 64'(dn), 64'd0);
      checkOutput("abortBusy", 64'(busy32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      inQ.delete();
      expQ.delete();
      randomBlock();
      enqueueBlock(1'b0, 64);
      runStream(1'b0, 64, 1, 0);

      $display("[TB] SHA-512 abc-style block");
      for (int i = 0; i < 16; i++) blk[i] = 64'h0;
      blk[0]  = 64'h6162_6380_0000_0000;
      blk[15] = 64'h18;
      enqueueBlock(1'b1, 80);
      runStream(1'b1, 80, 1, 0);
      checkOutput("w64W16", got[16], 64'h6162_6380_0000_0000);
      checkOutput("w64W17", got[17], 64'h0003_0000_0000_00C0);

      $display("[TB] back-to-back blocks with in_valid held high");
      randomBlock();
      enqueueBlock(1'b0, 64);
      randomBlock();
      enqueueBlock(1'b0, 64);
      runStream(1'b0, 64, 0, 0);

      randomBlock();
      enqueueBlock(1'b1, 80);
      randomBlock();
      enqueueBlock(1'b1, 80);
      runStream(1'b1, 80, 1, 0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
